// File: rtl/button_bank.sv
// Bank of independent push-button conditioners: synchroniser, debouncer,
// press/release edge pulses, toggle flip-flop and long-press (hold) detector.
module button_bank #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter bit          INVERT      = 1'b0
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] toggle_clr,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  // 'release' is a reserved word, hence the suffix.
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] toggle,
  output logic [N_CH-1:0] hold
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  // Sync flops reset to the idle raw level so reset release looks like "not pressed".
  localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{INVERT}};

  logic [SYNC_STAGES-1:0] sync_q     [N_CH];
  logic [SYNC_STAGES-1:0] sync_d     [N_CH];
  logic [DB_W-1:0]        db_cnt_q   [N_CH];
  logic [DB_W-1:0]        db_cnt_d   [N_CH];
  logic [HOLD_W-1:0]      hold_cnt_q [N_CH];
  logic [HOLD_W-1:0]      hold_cnt_d [N_CH];

  logic [N_CH-1:0] s;
  logic [N_CH-1:0] level_q,   level_d;
  logic [N_CH-1:0] press_q,   press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [N_CH-1:0] toggle_q,  toggle_d;
  logic [N_CH-1:0] hold_q,    hold_d;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    s         = '0;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    toggle_d  = toggle_q;
    hold_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      sync_d[i]     = {sync_q[i][SYNC_STAGES-2:0], in[i]};
      db_cnt_d[i]   = '0;
      hold_cnt_d[i] = '0;

      s[i] = sync_q[i][SYNC_STAGES-1] ^ INVERT;

      // Any sample equal to the current level restarts the stability count.
      if (s[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = s[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end

      // Pulses are registered alongside level so they coincide with its new value.
      press_d[i]   =  level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] &  level_q[i];

      if (toggle_clr[i]) begin
        toggle_d[i] = 1'b0;
      end else if (press_d[i]) begin
        toggle_d[i] = ~toggle_q[i];
      end

      if (level_q[i]) begin
        hold_d[i]     = (hold_cnt_q[i] == HOLD_LAST);
        hold_cnt_d[i] = (hold_cnt_q[i] == HOLD_MAX) ? HOLD_MAX : hold_cnt_q[i] + 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      // NOTE: counter arrays are real per-channel state, so each element is reset explicitly.
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i]     <= SYNC_IDLE;
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
      hold_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i]     <= sync_d[i];
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      hold_q    <= hold_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign toggle        = toggle_q;
  assign hold          = hold_q;

endmodule
